div_share_arbiter: RTL and testbench

- Round-robin arbiter that shares one restoring_division unit among NUM_REQ requesters.
- Accepts one operation at a time from a requester and issues it to the divider over its src valid/ready handshake.
- Collects the result over the divider's dest handshake and returns it to the granted requester on a shared response bus.
- Handles divide-by-zero locally, without using the divider.

---
 rtl/div_share_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_div_share_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_arbiter.sv
`timescale 1ns/1ps
// div_share_arbiter
// Round-robin arbiter that lets NUM_REQ requesters share a single
// restoring divider. One operation is in flight at a time: an operation is
// accepted from the granted requester, handed to the divider over its src
// handshake, its result is collected over the dest handshake and returned
// on a shared response bus. A zero divisor is answered locally
// (quotient all ones, remainder = dividend) without touching the divider.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req_valid/req_ready        per-requester operation handshake
//   req_dividend/req_divisor   packed operands, slice [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready        per-requester response handshake
//   rsp_quotient/rsp_remainder shared result bus
//   rsp_div0, rsp_id           divide-by-zero flag, owning requester
//   div_src_*/div_dividend/div_divisor   operand channel to the divider
//   div_dest_*/div_quotient/div_remainder result channel from the divider
//   busy                       high whenever an operation is in progress
module div_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 16,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
   input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
   output logic [NUM_REQ-1:0]       rsp_valid,
   input  logic [NUM_REQ-1:0]       rsp_ready,
   output logic [WIDTH-1:0]         rsp_quotient,
   output logic [WIDTH-1:0]         rsp_remainder,
   output logic                     rsp_div0,
   output logic [IDW-1:0]           rsp_id,
   output logic                     div_src_valid,
   input  logic                     div_src_ready,
   output logic [WIDTH-1:0]         div_dividend,
   output logic [WIDTH-1:0]         div_divisor,
   input  logic                     div_dest_valid,
   output logic                     div_dest_ready,
   input  logic [WIDTH-1:0]         div_quotient,
   input  logic [WIDTH-1:0]         div_remainder,
   output logic                     busy
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   logic [1:0]       state_r;
   logic [IDW-1:0]   rr_ptr_r;
   logic [IDW-1:0]   grant_r;
   logic [WIDTH-1:0] dividend_r;
   logic [WIDTH-1:0] divisor_r;
   logic [WIDTH-1:0] quot_r;
   logic [WIDTH-1:0] rem_r;
   logic             div0_r;
   logic [IDW-1:0]   rsp_id_r;

   logic             found_s;
   logic [IDW-1:0]   pick_s;
   logic [WIDTH-1:0] pick_dvd_s;
   logic [WIDTH-1:0] pick_dvs_s;
   logic             rsp_hs_s;

   // Round-robin search: first asserted req_valid at or after rr_ptr, wrapping.
   always_comb begin
      found_s = 1'b0;
      pick_s  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found_s && req_valid[(int'(rr_ptr_r) + k) % NUM_REQ]) begin
            found_s = 1'b1;
            pick_s  = IDW'((int'(rr_ptr_r) + k) % NUM_REQ);
         end else begin
            found_s = found_s;
         end
      end
   end

   assign pick_dvd_s = req_dividend[int'(pick_s)*WIDTH +: WIDTH];
   assign pick_dvs_s = req_divisor[int'(pick_s)*WIDTH +: WIDTH];

   // Accept strobe: combinational in req_valid, only while idle.
   always_comb begin
      req_ready = '0;
      if ((state_r == ST_IDLE) && found_s) begin
         req_ready[pick_s] = 1'b1;
      end else begin
         req_ready = '0;
      end
   end

   // Response valid is routed only to the requester that owns the grant.
   always_comb begin
      rsp_valid = '0;
      if (state_r == ST_RESP) begin
         rsp_valid[grant_r] = 1'b1;
      end else begin
         rsp_valid = '0;
      end
   end

   // Only the granted requester's rsp_ready can complete the response.
   assign rsp_hs_s       = (state_r == ST_RESP) && rsp_ready[grant_r];

   assign div_src_valid  = (state_r == ST_ISSUE);
   assign div_dest_ready = (state_r == ST_WAIT);
   assign busy           = (state_r != ST_IDLE);
   assign div_dividend   = dividend_r;
   assign div_divisor    = divisor_r;
   assign rsp_quotient   = quot_r;
   assign rsp_remainder  = rem_r;
   assign rsp_div0       = div0_r;
   assign rsp_id         = rsp_id_r;

   // Operation FSM; result-side registers load only on entry to RESP so the
   // response bus keeps its last value everywhere else.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         rr_ptr_r   <= '0;
         grant_r    <= '0;
         dividend_r <= '0;
         divisor_r  <= '0;
         quot_r     <= '0;
         rem_r      <= '0;
         div0_r     <= 1'b0;
         rsp_id_r   <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (found_s) begin
                  grant_r    <= pick_s;
                  dividend_r <= pick_dvd_s;
                  divisor_r  <= pick_dvs_s;
                  if (pick_dvs_s == {WIDTH{1'b0}}) begin
                     quot_r   <= {WIDTH{1'b1}};
                     rem_r    <= pick_dvd_s;
                     div0_r   <= 1'b1;
                     rsp_id_r <= pick_s;
                     state_r  <= ST_RESP;
                  end else begin
                     state_r  <= ST_ISSUE;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               if (div_src_ready) begin
                  state_r <= ST_WAIT;
               end else begin
                  state_r <= ST_ISSUE;
               end
            end
            ST_WAIT: begin
               if (div_dest_valid) begin
                  quot_r   <= div_quotient;
                  rem_r    <= div_remainder;
                  div0_r   <= 1'b0;
                  rsp_id_r <= grant_r;
                  state_r  <= ST_RESP;
               end else begin
                  state_r  <= ST_WAIT;
               end
            end
            ST_RESP: begin
               if (rsp_hs_s) begin
                  if (grant_r == IDW'(NUM_REQ - 1)) begin
                     rr_ptr_r <= '0;
                  end else begin
                     rr_ptr_r <= grant_r + IDW'(1);
                  end
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_RESP;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_share_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for div_share_arbiter with a behavioural divider stub.
module tb_div_share_arbiter;

   localparam int N  = 4;
   localparam int W  = 16;
   localparam int IW = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
   logic [N*W-1:0]   req_dividend, req_divisor;
   logic [W-1:0]     rsp_quotient, rsp_remainder;
   logic             rsp_div0;
   logic [IW-1:0]    rsp_id;
   logic             div_src_valid;
   logic             div_src_ready = 1'b0;
   logic [W-1:0]     div_dividend, div_divisor;
   logic             div_dest_valid = 1'b0;
   logic             div_dest_ready;
   logic [W-1:0]     div_quotient = '0;
   logic [W-1:0]     div_remainder = '0;
   logic             busy;

   div_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .IDW(IW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_dividend(req_dividend), .req_divisor(req_divisor),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
      .rsp_div0(rsp_div0), .rsp_id(rsp_id),
      .div_src_valid(div_src_valid), .div_src_ready(div_src_ready),
      .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_dest_valid(div_dest_valid), .div_dest_ready(div_dest_ready),
      .div_quotient(div_quotient), .div_remainder(div_remainder),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(string name);
      total++;
      bad++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   typedef struct {
      int         id;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic       d0;
   } exp_t;

   exp_t           exp_q[$];
   logic [2*W-1:0] iss_q[$];
   logic [W-1:0]   op_a [N];
   logic [W-1:0]   op_b [N];
   int             model_rr = 0;

   logic [N-1:0]   hold_rsp = '0;
   bit             rand_rsp = 1'b0;
   bit             rand_src = 1'b0;
   bit             src_block = 1'b0;
   bit             stale_en = 1'b0;
   int             lat_force = -1;
   logic [N-1:0]   acc_n = '0;

   // Requester driver: drop req_valid after its handshake, drive rsp_ready.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         req_valid = req_valid & ~acc_n;
         for (int i = 0; i < N; i++)
            rsp_ready[i] = hold_rsp[i] ? 1'b0 : (rand_rsp ? 1'($urandom % 2) : 1'b1);
      end
   end

   // Behavioural divider: random latency, plain arithmetic result.
   logic [W-1:0] sa, sb;
   bit s_src_hs, s_dst_hs, s_rst;
   int phase = 0;
   int cnt = 0;
   initial begin
      forever begin
         @(negedge clk);
         s_src_hs = div_src_valid && div_src_ready;
         s_dst_hs = div_dest_valid && div_dest_ready;
         sa = div_dividend;
         sb = div_divisor;
         s_rst = rst;
         @(posedge clk);
         #3;
         if (s_rst) begin
            phase = 0;
            div_dest_valid = 1'b0;
         end else begin
            case (phase)
               0: begin
                  if (s_src_hs) begin
                     div_quotient  = (sb == 0) ? {W{1'b1}} : sa / sb;
                     div_remainder = (sb == 0) ? sa : sa % sb;
                     cnt = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 4));
                     if (cnt == 0) begin
                        div_dest_valid = 1'b1;
                        phase = 2;
                     end else begin
                        phase = 1;
                     end
                  end else if (stale_en) begin
                     div_dest_valid = 1'b1;
                     div_quotient   = 16'hDEAD;
                     div_remainder  = 16'hBEEF;
                  end else begin
                     div_dest_valid = 1'b0;
                  end
               end
               1: begin
                  cnt--;
                  if (cnt <= 0) begin
                     div_dest_valid = 1'b1;
                     phase = 2;
                  end
               end
               2: begin
                  if (s_dst_hs) begin
                     div_dest_valid = 1'b0;
                     phase = 0;
                  end
               end
               default: phase = 0;
            endcase
         end
         div_src_ready = (phase == 0) && !src_block && (rand_src ? ($urandom % 3 != 0) : 1'b1);
      end
   end

   // Monitor / scoreboard.
   bit           rst_prev = 1'b0;
   bit           prev_src_wait = 1'b0;
   bit           prev_rsp_wait = 1'b0;
   logic [2*W-1:0] prev_ops;
   logic [N-1:0] prev_rsp_valid;
   logic [2*W+IW:0] prev_rsp_data;
   bit           div0_chk = 1'b0;
   int           div0_id = 0;
   logic [N-1:0] acc, rhs;
   int           g, eg, rk;
   exp_t         e;
   logic [2*W-1:0] ops;
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            iss_q.delete();
            model_rr = 0;
            acc_n = '0;
            div0_chk = 1'b0;
            prev_src_wait = 1'b0;
            prev_rsp_wait = 1'b0;
            rst_prev = 1'b1;
         end else begin
            if (rst_prev) begin
               check("rst_rsp_valid", rsp_valid, 0);
               check("rst_busy", busy, 0);
               check("rst_div_handshake", {div_src_valid, div_dest_ready}, 0);
               check("rst_rsp_data", {rsp_quotient, rsp_remainder}, 0);
               check("rst_rsp_flags", {rsp_div0, rsp_id}, 0);
               check("rst_div_ops", {div_dividend, div_divisor}, 0);
               if (req_valid == '0) check("rst_req_ready", req_ready, 0);
            end
            check("req_ready_onehot", $countones(req_ready) > 1, 0);
            check("rsp_valid_onehot", $countones(rsp_valid) > 1, 0);
            check("req_ready_while_busy", busy ? req_ready : '0, 0);
            if (prev_src_wait) begin
               check("src_valid_held", div_src_valid, 1);
               check("src_ops_stable", {div_dividend, div_divisor}, prev_ops);
            end
            if (prev_rsp_wait) begin
               check("rsp_valid_held", rsp_valid, prev_rsp_valid);
               check("rsp_data_stable", {rsp_quotient, rsp_remainder} != prev_rsp_data[2*W+IW:IW+1], 0);
               check("rsp_flags_stable", {rsp_div0, rsp_id}, prev_rsp_data[IW:0]);
            end
            if (div0_chk) begin
               check("div0_latency", rsp_valid, 1 << div0_id);
               div0_chk = 1'b0;
            end
            if (div_src_valid && div_src_ready) begin
               if (iss_q.size() == 0) begin
                  check("src_unexpected", 1, 0);
               end else begin
                  ops = iss_q.pop_front();
                  check("src_operands", {div_dividend, div_divisor}, ops);
               end
            end
            if (rsp_valid != '0 && exp_q.size() == 0) check("rsp_unexpected", rsp_valid, 0);
            rhs = rsp_valid & rsp_ready;
            if (rhs != '0 && exp_q.size() != 0) begin
               rk = 0;
               for (int k = 0; k < N; k++) if (rhs[k]) rk = k;
               e = exp_q.pop_front();
               check("rsp_owner", rk, e.id);
               check("rsp_id", rsp_id, e.id);
               check("rsp_quotient", rsp_quotient, e.q);
               check("rsp_remainder", rsp_remainder, e.r);
               check("rsp_div0", rsp_div0, e.d0);
               model_rr = (e.id + 1) % N;
            end
            acc = req_valid & req_ready;
            if (acc != '0) begin
               g = 0;
               for (int k = 0; k < N; k++) if (acc[k]) g = k;
               eg = -1;
               for (int k = 0; k < N; k++)
                  if (eg < 0 && req_valid[(model_rr + k) % N]) eg = (model_rr + k) % N;
               check("grant", g, eg);
               if (op_b[g] == 0) begin
                  exp_q.push_back('{id: g, q: {W{1'b1}}, r: op_a[g], d0: 1'b1});
                  div0_chk = 1'b1;
                  div0_id = g;
               end else begin
                  exp_q.push_back('{id: g, q: op_a[g] / op_b[g], r: op_a[g] % op_b[g], d0: 1'b0});
                  iss_q.push_back({op_a[g], op_b[g]});
               end
            end
            acc_n = acc;
            prev_src_wait = div_src_valid && !div_src_ready;
            prev_ops = {div_dividend, div_divisor};
            prev_rsp_wait = (rsp_valid != '0) && ((rsp_valid & rsp_ready) == '0);
            prev_rsp_valid = rsp_valid;
            prev_rsp_data = {rsp_quotient, rsp_remainder, rsp_div0, rsp_id};
            rst_prev = 1'b0;
         end
      end
   end

   task automatic tick(int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic set_req(int i, logic [W-1:0] a, logic [W-1:0] b);
      int t = 0;
      while (req_valid[i] && t < 1000) begin
         tick(1);
         t++;
      end
      if (t >= 1000) timeout_fail("set_req_wait");
      op_a[i] = a;
      op_b[i] = b;
      req_dividend[i*W +: W] = a;
      req_divisor[i*W +: W]  = b;
      req_valid[i] = 1'b1;
   endtask

   task automatic drain();
      int t = 0;
      while ((req_valid != '0 || exp_q.size() != 0 || busy) && t < 3000) begin
         tick(1);
         t++;
      end
      if (t >= 3000) timeout_fail("drain");
   endtask

   initial begin
      int t;
      rst = 1'b1;
      req_valid = '0;
      req_dividend = '0;
      req_divisor = '0;
      rsp_ready = '1;
      for (int i = 0; i < N; i++) begin
         op_a[i] = '0;
         op_b[i] = '0;
      end
      tick(3);
      rst = 1'b0;
      tick(1);

      // single request
      set_req(0, 16'd100, 16'd7);
      drain();

      // all four requesters together, then requester 0 again
      for (int i = 0; i < N; i++) set_req(i, W'(40 + i), 16'd3);
      drain();
      set_req(0, 16'd40, 16'd3);
      drain();

      // divide by zero
      set_req(2, 16'h1234, 16'h0000);
      drain();

      // divider backpressure
      src_block = 1'b1;
      set_req(1, 16'd1000, 16'd9);
      tick(6);
      src_block = 1'b0;
      drain();

      // response backpressure with a competing request arriving meanwhile
      hold_rsp[1] = 1'b1;
      set_req(1, 16'hFFFF, 16'h0010);
      t = 0;
      while (!rsp_valid[1] && t < 200) begin
         tick(1);
         t++;
      end
      if (t >= 200) timeout_fail("rsp1_wait");
      set_req(0, 16'd5, 16'd2);
      tick(10);
      hold_rsp[1] = 1'b0;
      drain();

      // leave rr_ptr at 3, then reset in the middle of a divider wait
      set_req(2, 16'd9, 16'd3);
      drain();
      lat_force = 30;
      set_req(1, 16'd77, 16'd4);
      t = 0;
      while (!div_dest_ready && t < 200) begin
         tick(1);
         t++;
      end
      if (t >= 200) timeout_fail("wait_state");
      tick(2);
      rst = 1'b1;
      req_valid = '0;
      tick(1);
      rst = 1'b0;
      lat_force = -1;
      stale_en = 1'b1;
      tick(3);
      stale_en = 1'b0;
      tick(1);
      set_req(3, 16'd50, 16'd5);
      set_req(0, 16'd60, 16'd6);
      drain();

      // wrap to requester 3 first, late arrival from requester 1
      set_req(2, 16'd9, 16'd3);
      drain();
      set_req(3, 16'd100, 16'd10);
      set_req(0, 16'd200, 16'd20);
      t = 0;
      while (!busy && t < 50) begin
         tick(1);
         t++;
      end
      if (t >= 50) timeout_fail("busy_wait");
      tick(1);
      set_req(1, 16'd300, 16'd30);
      drain();

      // randomized traffic
      rand_rsp = 1'b1;
      rand_src = 1'b1;
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && ($urandom % 8 == 0))
               set_req(i, W'($urandom), ($urandom % 6 == 0) ? 16'h0000 : W'($urandom_range(1, 65535)));
         end
         tick(1);
      end
      rand_rsp = 1'b0;
      rand_src = 1'b0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

endmodule
